// File: rtl/stack_alu_pipe.sv
// Signed operand stack ALU with valid/ready commands and a shift-add multiplier.
// Define STACK_ALU_SATURATE_EN to clamp ADD/SUB/MUL results on overflow.
module stack_alu_pipe #(
  parameter int DATA_WIDTH = 8,
  parameter int STACK_SIZE = 64,
  localparam int DEPTH_W = $clog2(STACK_SIZE + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            opcode,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  overflow,
  output logic                  err,
  output logic [1:0]            err_code,
  output logic [DEPTH_W-1:0]    depth,
  output logic                  empty,
  output logic                  full
);
  localparam int W  = DATA_WIDTH;
  localparam int AW = $clog2(STACK_SIZE);
  localparam int CW = $clog2(W) + 1;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_PUSH = 3'd1;
  localparam logic [2:0] OP_POP  = 3'd2;
  localparam logic [2:0] OP_ADD  = 3'd3;
  localparam logic [2:0] OP_SUB  = 3'd4;
  localparam logic [2:0] OP_MUL  = 3'd5;
  localparam logic [2:0] OP_DUP  = 3'd6;
  localparam logic [2:0] OP_SWAP = 3'd7;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [DEPTH_W-1:0]   depth_q, depth_d;
  logic                 out_valid_q, out_valid_d;
  logic [W-1:0]         out_data_q, out_data_d;
  logic                 ovf_q, ovf_d;
  logic                 err_q, err_d;
  logic [1:0]           err_code_q, err_code_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*W-1:0]       acc_q, acc_d;
  logic [2*W-1:0]       mcand_q, mcand_d;
  logic [W-1:0]         mplier_q, mplier_d;
  logic                 neg_q, neg_d;

  logic [W-1:0]         mem_q [STACK_SIZE];
  logic                 we_a, we_b;
  logic [AW-1:0]        wa_a, wa_b;
  logic [W-1:0]         wd_a, wd_b;

  logic [AW-1:0]        top_idx, tos_idx, nos_idx;
  logic [W-1:0]         tos, nos, sum, dif, mag_n, mag_t;
  logic [W-1:0]         add_res, sub_res, mul_res;
  logic                 add_ovf, sub_ovf, mul_ovf;
  logic [2*W-1:0]       acc_nx, prod;
  logic                 accept, under, over;

  assign top_idx = AW'(depth_q);
  assign tos_idx = AW'(depth_q - DEPTH_W'(1));
  assign nos_idx = AW'(depth_q - DEPTH_W'(2));
  assign tos     = mem_q[tos_idx];
  assign nos     = mem_q[nos_idx];

  assign sum     = nos + tos;
  assign dif     = nos - tos;
  assign add_ovf = (nos[W-1] == tos[W-1]) && (sum[W-1] != nos[W-1]);
  assign sub_ovf = (nos[W-1] != tos[W-1]) && (dif[W-1] != nos[W-1]);

  // Multiply magnitudes, restore the sign once at the end.
  assign mag_n   = nos[W-1] ? -nos : nos;
  assign mag_t   = tos[W-1] ? -tos : tos;
  assign acc_nx  = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign prod    = neg_q ? -acc_nx : acc_nx;
  assign mul_ovf = !((&prod[2*W-1:W-1]) || !(|prod[2*W-1:W-1]));

`ifdef STACK_ALU_SATURATE_EN
  localparam logic [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};
  assign add_res = add_ovf ? (nos[W-1] ? SMIN : SMAX) : sum;
  assign sub_res = sub_ovf ? (nos[W-1] ? SMIN : SMAX) : dif;
  assign mul_res = mul_ovf ? (prod[2*W-1] ? SMIN : SMAX) : prod[W-1:0];
`else
  assign add_res = sum;
  assign sub_res = dif;
  assign mul_res = prod[W-1:0];
`endif

  assign accept = in_valid && in_ready;
  assign under  = ((opcode == OP_ADD || opcode == OP_SUB ||
                    opcode == OP_MUL || opcode == OP_SWAP) &&
                   depth_q < DEPTH_W'(2)) ||
                  ((opcode == OP_POP || opcode == OP_DUP) &&
                   depth_q == '0);
  assign over   = (opcode == OP_PUSH || opcode == OP_DUP) &&
                  depth_q == DEPTH_W'(STACK_SIZE);

  always_comb begin
    state_d     = state_q;
    depth_d     = depth_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    ovf_d       = ovf_q;
    err_d       = 1'b0;
    err_code_d  = err_code_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    neg_d       = neg_q;
    we_a        = 1'b0;
    wa_a        = top_idx;
    wd_a        = in_data;
    we_b        = 1'b0;
    wa_b        = nos_idx;
    wd_b        = tos;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (under) begin
            err_d      = 1'b1;
            err_code_d = 2'b01;
          end else if (over) begin
            err_d      = 1'b1;
            err_code_d = 2'b10;
          end else begin
            unique case (opcode)
              OP_NOP: ;
              OP_PUSH: begin
                we_a    = 1'b1;
                depth_d = depth_q + DEPTH_W'(1);
              end
              OP_POP: begin
                out_valid_d = 1'b1;
                out_data_d  = tos;
                ovf_d       = 1'b0;
                depth_d     = depth_q - DEPTH_W'(1);
              end
              OP_ADD: begin
                we_b        = 1'b1;
                wd_b        = add_res;
                out_valid_d = 1'b1;
                out_data_d  = add_res;
                ovf_d       = add_ovf;
                depth_d     = depth_q - DEPTH_W'(1);
              end
              OP_SUB: begin
                we_b        = 1'b1;
                wd_b        = sub_res;
                out_valid_d = 1'b1;
                out_data_d  = sub_res;
                ovf_d       = sub_ovf;
                depth_d     = depth_q - DEPTH_W'(1);
              end
              OP_MUL: begin
                state_d  = S_MUL;
                cnt_d    = '0;
                acc_d    = '0;
                mcand_d  = {{W{1'b0}}, mag_n};
                mplier_d = mag_t;
                neg_d    = nos[W-1] ^ tos[W-1];
              end
              OP_DUP: begin
                we_a    = 1'b1;
                wd_a    = tos;
                depth_d = depth_q + DEPTH_W'(1);
              end
              OP_SWAP: begin
                we_a = 1'b1;
                wa_a = tos_idx;
                wd_a = nos;
                we_b = 1'b1;
              end
            endcase
          end
        end
      end
      S_MUL: begin
        acc_d    = acc_nx;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) begin
          state_d     = S_DONE;
          we_b        = 1'b1;
          wd_b        = mul_res;
          out_valid_d = 1'b1;
          out_data_d  = mul_res;
          ovf_d       = mul_ovf;
          depth_d     = depth_q - DEPTH_W'(1);
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      depth_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= 2'b00;
      cnt_q       <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      neg_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      depth_q     <= depth_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      ovf_q       <= ovf_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      neg_q       <= neg_d;
    end
  end

  // Stack storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (we_a) mem_q[wa_a] <= wd_a;
    if (we_b) mem_q[wa_b] <= wd_b;
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign overflow  = ovf_q;
  assign err       = err_q;
  assign err_code  = err_code_q;
  assign depth     = depth_q;
  assign empty     = (depth_q == '0);
  assign full      = (depth_q == DEPTH_W'(STACK_SIZE));
endmodule
